// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational alu.
// Requests use valid/ready handshakes with round-robin arbitration. A
// one-entry registered buffer holds the last result, and the port that owns
// it can apply backpressure through its rsp_ready input.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_input0,
    input  logic [DATA_WIDTH-1:0] req0_input1,
    input  logic [3:0]            req0_aluselect,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_input0,
    input  logic [DATA_WIDTH-1:0] req1_input1,
    input  logic [3:0]            req1_aluselect,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_out,
    output logic                  rsp_is_zero,
    output logic [DATA_WIDTH-1:0] alu_input0,
    output logic [DATA_WIDTH-1:0] alu_input1,
    output logic [3:0]            alu_aluselect,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_is_zero
);

    // Shift operations only use the low five bits of operand B.
    localparam logic [3:0] SEL_SLL = 4'd2;
    localparam logic [3:0] SEL_SRL = 4'd3;
    localparam logic [3:0] SEL_SRA = 4'd4;

    logic                  buf_valid_q, buf_valid_d;
    logic                  buf_owner_q, buf_owner_d;
    logic                  rr_last_q, rr_last_d;
    logic [DATA_WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic                  rsp_is_zero_q, rsp_is_zero_d;

    logic                  grant_s;
    logic                  owner_ready_s;
    logic                  can_accept_s;
    logic                  drain_s;
    logic                  accept0_s;
    logic                  accept1_s;
    logic [DATA_WIDTH-1:0] op_b_s;

    // Pick the winning port, and decide whether the buffer can take a new result this cycle.
    always_comb begin
        grant_s       = 1'b0;
        owner_ready_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~rr_last_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (buf_owner_q) begin
            owner_ready_s = rsp1_ready;
        end else begin
            owner_ready_s = rsp0_ready;
        end
        drain_s      = buf_valid_q & owner_ready_s;
        can_accept_s = ~buf_valid_q | owner_ready_s;
        accept0_s    = can_accept_s & req0_valid & ~grant_s & ~rst;
        accept1_s    = can_accept_s & req1_valid &  grant_s & ~rst;
    end

    // Route the granted port's operation to the alu, masking shift amounts to five bits.
    always_comb begin
        alu_input0    = req0_input0;
        op_b_s        = req0_input1;
        alu_aluselect = req0_aluselect;
        if (grant_s) begin
            alu_input0    = req1_input0;
            op_b_s        = req1_input1;
            alu_aluselect = req1_aluselect;
        end else begin
            alu_input0    = req0_input0;
            op_b_s        = req0_input1;
            alu_aluselect = req0_aluselect;
        end
        case (alu_aluselect)
            SEL_SLL, SEL_SRL, SEL_SRA: alu_input1 = {{(DATA_WIDTH-5){1'b0}}, op_b_s[4:0]};
            default:                   alu_input1 = op_b_s;
        endcase
    end

    // Compute the next buffer and round-robin state: an accept refills, a drain empties, otherwise hold.
    always_comb begin
        buf_valid_d   = buf_valid_q;
        buf_owner_d   = buf_owner_q;
        rr_last_d     = rr_last_q;
        rsp_out_d     = rsp_out_q;
        rsp_is_zero_d = rsp_is_zero_q;
        if (accept0_s || accept1_s) begin
            buf_valid_d   = 1'b1;
            buf_owner_d   = accept1_s;
            rr_last_d     = accept1_s;
            rsp_out_d     = alu_out;
            rsp_is_zero_d = alu_is_zero;
        end else if (drain_s) begin
            buf_valid_d = 1'b0;
        end else begin
            buf_valid_d = buf_valid_q;
        end
    end

    // State registers. Reset discards any buffered result and gives port 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q   <= 1'b0;
            buf_owner_q   <= 1'b0;
            rr_last_q     <= 1'b1;
            rsp_out_q     <= {DATA_WIDTH{1'b0}};
            rsp_is_zero_q <= 1'b0;
        end else begin
            buf_valid_q   <= buf_valid_d;
            buf_owner_q   <= buf_owner_d;
            rr_last_q     <= rr_last_d;
            rsp_out_q     <= rsp_out_d;
            rsp_is_zero_q <= rsp_is_zero_d;
        end
    end

    assign req0_ready  = accept0_s;
    assign req1_ready  = accept1_s;
    assign rsp0_valid  = buf_valid_q & ~buf_owner_q;
    assign rsp1_valid  = buf_valid_q &  buf_owner_q;
    assign rsp_out     = rsp_out_q;
    assign rsp_is_zero = rsp_is_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed by
// random traffic. Results are checked against a transaction-level model.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_input0, req0_input1, req1_input0, req1_input1;
    logic [3:0]  req0_aluselect, req1_aluselect;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_out;
    logic        rsp_is_zero;
    logic [31:0] alu_input0, alu_input1, alu_out;
    logic [3:0]  alu_aluselect;
    logic        alu_is_zero;

    int checks   = 0;
    int failures = 0;

    // Model state: contents of the result buffer and the last port served.
    bit        m_valid;
    bit        m_owner;
    bit        m_rr;
    bit [31:0] m_out;
    bit        m_zero;

    alu_share_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_input0(req0_input0), .req0_input1(req0_input1), .req0_aluselect(req0_aluselect),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_input0(req1_input0), .req1_input1(req1_input1), .req1_aluselect(req1_aluselect),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_is_zero(rsp_is_zero),
        .alu_input0(alu_input0), .alu_input1(alu_input1), .alu_aluselect(alu_aluselect),
        .alu_out(alu_out), .alu_is_zero(alu_is_zero)
    );

    // Reference alu: the shift amount is the full operand B, so unmasked shift operands would show up in the result.
    function automatic bit [31:0] alu_ref(input bit [31:0] a, input bit [31:0] b, input bit [3:0] sel);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b;
            4'd3:    return a >> b;
            4'd4:    return 32'($signed(a) >>> b);
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return ~(a | b);
            4'd11:   return a;
            4'd12:   return b;
            4'd13:   return ~a;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out     = alu_ref(alu_input0, alu_input1, alu_aluselect);
    assign alu_is_zero = (alu_out == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Operand B as the alu should see it: shifts use only five bits.
    function automatic bit [31:0] eff_b(input bit [31:0] b, input bit [3:0] sel);
        if (sel == 4'd2 || sel == 4'd3 || sel == 4'd4) return {27'd0, b[4:0]};
        return b;
    endfunction

    // One cycle: inputs are already applied. Check outputs mid-cycle, then advance the model over the edge.
    task automatic step();
        bit        win;
        bit        room;
        bit        e_r0, e_r1;
        bit [31:0] a, b;
        bit [3:0]  s;
        bit [31:0] res;
        #3;
        if (req0_valid && req1_valid) win = (m_rr == 1'b1) ? 1'b0 : 1'b1;
        else win = req1_valid;
        room = !m_valid || (m_owner ? rsp1_ready : rsp0_ready);
        e_r0 = !rst && room && req0_valid && (win == 1'b0);
        e_r1 = !rst && room && req1_valid && (win == 1'b1);
        a = win ? req1_input0 : req0_input0;
        b = eff_b(win ? req1_input1 : req0_input1, win ? req1_aluselect : req0_aluselect);
        s = win ? req1_aluselect : req0_aluselect;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_valid && !m_owner});
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_valid && m_owner});
        chk("rsp_out", rsp_out, m_out);
        chk("rsp_is_zero", {31'd0, rsp_is_zero}, {31'd0, m_zero});
        if (req0_valid || req1_valid) begin
            chk("alu_sel", {28'd0, alu_aluselect}, {28'd0, s});
            chk("alu_in0", alu_input0, a);
            chk("alu_in1", alu_input1, b);
        end
        res = alu_ref(a, b, s);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_owner = 1'b0; m_rr = 1'b1; m_out = 32'd0; m_zero = 1'b0;
        end else if (e_r0 || e_r1) begin
            m_valid = 1'b1; m_owner = e_r1; m_rr = e_r1; m_out = res; m_zero = (res == 32'd0);
        end else if (m_valid && (m_owner ? rsp1_ready : rsp0_ready)) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic set0(input bit v, input bit [31:0] a, input bit [31:0] b, input bit [3:0] s);
        req0_valid = v; req0_input0 = a; req0_input1 = b; req0_aluselect = s;
    endtask

    task automatic set1(input bit v, input bit [31:0] a, input bit [31:0] b, input bit [3:0] s);
        req1_valid = v; req1_input0 = a; req1_input1 = b; req1_aluselect = s;
    endtask

    initial begin
        rst = 1'b1;
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        m_valid = 1'b0; m_owner = 1'b0; m_rr = 1'b1; m_out = 32'd0; m_zero = 1'b0;
        @(posedge clk);
        #1;
        // Requests during reset must not be accepted.
        set0(1'b1, 32'd1, 32'd1, 4'd0);
        step();
        rst = 1'b0;

        // ADD 5+3 on port 0.
        set0(1'b1, 32'd5, 32'd3, 4'd0);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        step();
        chk("add_result", rsp_out, 32'd8);

        // Both ports valid every cycle: the grant alternates.
        set0(1'b1, 32'd7, 32'd7, 4'd1);
        set1(1'b1, 32'hF0, 32'h0F, 4'd6);
        for (int i = 0; i < 6; i++) step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        step();

        // Shift operand masking on port 1.
        set1(1'b1, 32'd1, 32'h124, 4'd2);
        step();
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        step();
        chk("sll_result", rsp_out, 32'h10);

        // Backpressure: port 0 holds its XOR result while port 1 waits.
        rsp0_ready = 1'b0;
        set0(1'b1, 32'hA, 32'h5, 4'd7);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        set1(1'b1, 32'd2, 32'd3, 4'd0);
        for (int i = 0; i < 3; i++) step();
        chk("xor_hold", rsp_out, 32'hF);
        rsp0_ready = 1'b1;
        step();
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        step();

        // Unused select 15: result 0 with is_zero set.
        set0(1'b1, 32'h1234, 32'h5678, 4'd15);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        step();
        chk("sel15_zero", {31'd0, rsp_is_zero}, 32'd1);

        // Reset while the buffer is full and stalled.
        rsp0_ready = 1'b0;
        set0(1'b1, 32'd9, 32'd1, 4'd0);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp0_ready = 1'b1;
        set0(1'b1, 32'd4, 32'd4, 4'd0);
        set1(1'b1, 32'd4, 32'd4, 4'd1);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set0(($urandom % 4) != 0, ($urandom % 2) ? $urandom : $urandom % 16,
                 ($urandom % 2) ? $urandom : $urandom % 40, 4'($urandom % 16));
            set1(($urandom % 4) != 0, ($urandom % 2) ? $urandom : $urandom % 16,
                 ($urandom % 2) ? $urandom : $urandom % 40, 4'($urandom % 16));
            rsp0_ready = ($urandom % 10) < 7;
            rsp1_ready = ($urandom % 10) < 7;
            rst = ($urandom % 64) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational alu instance between two requesters, e.g. the integer execute stage (port 0) and the address-generation/branch unit (port 1).
- Uses valid/ready request handshakes, round-robin arbitration and a one-entry registered result buffer with per-port response backpressure.
- Drives the alu's input0/input1/aluselect and captures its out/is_zero.

Parameters:
- DATA_WIDTH, 32, operand and result width; must equal the shared alu's DATA_WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req0_valid / req1_valid  input  1  requester N presents an operation
- req0_ready / req1_ready  output  1  requester N operation accepted this cycle (valid & ready)
- req0_input0 / req1_input0  input  DATA_WIDTH  operand A
- req0_input1 / req1_input1  input  DATA_WIDTH  operand B
- req0_aluselect / req1_aluselect  input  4  alu operation code 0..13
- rsp0_valid / rsp1_valid  output  1  result buffer holds a result owned by port N
- rsp0_ready / rsp1_ready  input  1  port N consumes its result this cycle
- rsp_out  output  DATA_WIDTH  buffered result, shared by both ports, qualified by rspN_valid
- rsp_is_zero  output  1  buffered is_zero flag
- alu_input0  output  DATA_WIDTH  to shared alu input0
- alu_input1  output  DATA_WIDTH  to shared alu input1
- alu_aluselect  output  4  to shared alu aluselect
- alu_out  input  DATA_WIDTH  from shared alu out
- alu_is_zero  input  1  from shared alu is_zero

Behaviour:
- Reset (rst=1 at clk edge):
  - buf_valid=0, buf_owner=0, rr_last=1 (port 0 has priority first).
  - rsp_out=0, rsp_is_zero=0, rsp0_valid=rsp1_valid=0.
  - req0_ready and req1_ready are 0 while rst is high.
  - Reset mid-operation discards the buffered result with no response.
- can_accept = !buf_valid | (owner's rspN_ready) — a same-cycle drain-and-refill is allowed.
- Grant (combinational):
  - Only one valid: that port wins.
  - Both valid: the port != rr_last wins.
  - reqN_ready = can_accept & grant==N & !rst. At most one ready is high per cycle.
- alu_* outputs mux the granted port's fields; with no valid request they drive port 0's fields (don't-care).
- Shift masking: for aluselect 2, 3, 4, alu_input1 = {zeros, reqN_input1[4:0]}; otherwise it is passed unmodified.
- aluselect 14/15 are passed through; the alu returns 0 and is_zero=1, which are buffered normally.
- On accept (valid & ready): at the next edge, the buffer loads alu_out and alu_is_zero, buf_owner=N, buf_valid=1, rr_last=N.
  - Latency: request accepted in cycle T gives rspN_valid in cycle T+1.
- On drain without accept: buf_valid=0 at the next edge. rsp_out and rsp_is_zero hold their last value.
- rspN_valid = buf_valid & buf_owner==N. The non-owner's rsp_ready is ignored.
- Backpressure: while the buffer is full and the owner's rsp_ready=0, both req_ready stay 0 and the buffered contents are stable.
- rr_last updates only on accept. A lone requester may win on consecutive cycles.
- Sustained throughput is 1 operation/cycle while the owner holds rsp_ready=1.

Test Plan:
- Reset, then req0: input0=5, input1=3, aluselect=0, rsp0_ready=1 -> req0_ready=1 in cycle T; rsp0_valid=1, rsp_out=8, rsp_is_zero=0 in T+1; rsp1_valid=0.
- Both valid every cycle with rsp ready=1; req0 does SUB 7-7, req1 does OR 0xF0|0x0F -> grants alternate 0,1,0,1. Port 0 results are 0 with is_zero=1; port 1 results are 0xFF.
- req1 does SLL with input0=1, input1=0x00000124 -> alu_input1=4 and rsp_out=0x10.
- req0 does XOR 0xA^0x5 with rsp0_ready=0 for 3 cycles while req1 is valid -> rsp_out holds 0xF. req1_ready=0 throughout, then req1 is granted in the cycle rsp0_ready=1.
- req0 does aluselect=15 -> rsp_out=0, rsp_is_zero=1, one-cycle latency.
- rst asserted while the buffer is full with rsp0_ready=0 -> the next cycle shows rsp0_valid=0, rsp_out=0, and port 0 is granted first on simultaneous requests.
